// File: rtl/cplx_tree_sum_ctrl_if.sv
// Job control, chunk stream, adder-tree port and result signals of the complex tree-sum sequencer.
// Latency: none, wiring only.
// Backpressure: in_valid/in_ready on the chunk stream; result has none.
interface cplx_tree_sum_ctrl_if #(
    parameter int NI = 8
);
    logic                 start;
    logic [2:0]           chunk_cnt;
    logic                 busy;
    logic                 in_valid;
    logic                 in_ready;
    logic [NI*64-1:0]     in_data;
    logic [NI*64-1:0]     tree_inputs;
    logic [63:0]          tree_sum;
    logic [63:0]          result;
    logic                 result_valid;

    // Vector source plus adder tree side.
    modport master (
        output start, chunk_cnt, in_valid, in_data, tree_sum,
        input  busy, in_ready, tree_inputs, result, result_valid
    );

    // Sequencer side.
    modport slave (
        input  start, chunk_cnt, in_valid, in_data, tree_sum,
        output busy, in_ready, tree_inputs, result, result_valid
    );
endinterface

// File: rtl/cplx_tree_sum_ctrl.sv
// Sums 8..64 complex elements via a shared 8-input adder tree, re-reducing the partials through it (CPLX_TREE_CTRL_SKIP_REDUCE_EN skips that pass for K=1).
// Latency: result_valid K+2*TREE_LAT+4 cycles after start (TREE_LAT+3 for K=1 with the skip build), plus one per in_valid gap.
// Backpressure: in_ready high only in FEED; result has none and is held until the next job's capture.
module cplx_tree_sum_ctrl #(
    parameter int NI       = 8,
    parameter int TREE_LAT = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    cplx_tree_sum_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_FEED, S_DRAIN1, S_REDUCE, S_DRAIN2, S_DONE
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [2:0]          k_m1;          // chunks in this job minus one
    logic [2:0]          acc_cnt;       // chunks accepted so far
    logic [3:0]          cap_idx;       // tree sums captured so far
    logic [3:0]          cap_cnt_nxt;
    logic [63:0]         partial [NI];
    logic [NI*64-1:0]    tree_q;
    logic [63:0]         result_q;
    logic                tag_in;        // travels alongside tree_q
    logic [TREE_LAT-1:0] tag_pipe;      // mirrors the tree's pipeline depth
    logic                cap_now;
    logic                drain1_done;
    logic                skip_now;

    assign cap_now     = tag_pipe[TREE_LAT-1];
    assign cap_cnt_nxt = cap_idx + {3'd0, cap_now};
    // Counting this edge's capture lets DRAIN1 leave on the same edge the last partial lands.
    assign drain1_done = (cap_cnt_nxt == ({1'b0, k_m1} + 4'd1));

`ifdef CPLX_TREE_CTRL_SKIP_REDUCE_EN
    assign skip_now = (k_m1 == 3'd0);
`else
    assign skip_now = 1'b0;
`endif

    assign bus.tree_inputs = tree_q;
    assign bus.result      = result_q;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and state-decoded outputs.
    always_comb begin
        state_nxt        = state;
        bus.busy         = (state != S_IDLE);
        bus.in_ready     = (state == S_FEED);
        bus.result_valid = (state == S_DONE);
        case (state)
            S_IDLE:   if (bus.start) state_nxt = S_FEED;
            S_FEED:   if (bus.in_valid && (acc_cnt == k_m1)) state_nxt = S_DRAIN1;
            S_DRAIN1: if (drain1_done) state_nxt = skip_now ? S_DONE : S_REDUCE;
            S_REDUCE: state_nxt = S_DRAIN2;
            S_DRAIN2: if (cap_now) state_nxt = S_DONE;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Tree drive, tag pipe, partial capture and result update.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tree_q   <= '0;
            result_q <= '0;
            tag_in   <= 1'b0;
            tag_pipe <= '0;
            cap_idx  <= '0;
            acc_cnt  <= '0;
            k_m1     <= '0;
            for (int i = 0; i < NI; i++) partial[i] <= '0;
        end else begin
            // Tree sees zero and tag 0 unless a chunk or the partials are loaded below.
            tree_q      <= '0;
            tag_in      <= 1'b0;
            tag_pipe[0] <= tag_in;
            for (int i = 1; i < TREE_LAT; i++) tag_pipe[i] <= tag_pipe[i-1];

            if (cap_now) begin
                if (state == S_DRAIN2) begin
                    result_q <= bus.tree_sum;
                end else if (cap_idx < 4'(NI)) begin
                    partial[cap_idx[2:0]] <= bus.tree_sum;
                end
                cap_idx <= cap_cnt_nxt;
            end

            // partial[0] may be landing on this very edge, so take it from the tree.
            if ((state == S_DRAIN1) && drain1_done && skip_now) begin
                result_q <= cap_now ? bus.tree_sum : partial[0];
            end

            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        k_m1    <= bus.chunk_cnt;
                        acc_cnt <= '0;
                        cap_idx <= '0;
                        for (int i = 0; i < NI; i++) partial[i] <= '0;
                    end
                end
                S_FEED: begin
                    if (bus.in_valid) begin
                        tree_q  <= bus.in_data;
                        tag_in  <= 1'b1;
                        acc_cnt <= acc_cnt + 3'd1;
                    end
                end
                S_REDUCE: begin
                    // Unused slots were cleared at start, so they add +0.0+j0.0.
                    for (int i = 0; i < NI; i++) tree_q[64*i +: 64] <= partial[i];
                    tag_in <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_cplx_tree_sum_ctrl.sv
// Bench for cplx_tree_sum_ctrl: models the adder tree and checks sums and result timing against a whole-vector model.
// Latency: n/a.
// Backpressure: drives in_valid gaps, random or scripted.
module tb_cplx_tree_sum_ctrl;
    localparam int NI = 8;
    localparam int TL = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    logic [NI*64-1:0] jd [8];
    logic [63:0]      tree_pipe [TL];

    cplx_tree_sum_ctrl_if #(.NI(NI)) bus ();

    cplx_tree_sum_ctrl #(.NI(NI), .TREE_LAT(TL)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic real f2r(input logic [31:0] b);
        real v;
        int  e;
        if (b[30:0] == 31'd0) return 0.0;
        v = 1.0 + real'(b[22:0]) / 8388608.0;
        e = int'(b[30:23]) - 127;
        while (e > 0) begin v = v * 2.0; e--; end
        while (e < 0) begin v = v / 2.0; e++; end
        return b[31] ? -v : v;
    endfunction

    function automatic logic [31:0] r2f(input real x);
        real        a;
        int         e;
        logic       s;
        logic [22:0] m;
        if (x == 0.0) return 32'h0;
        s = (x < 0.0);
        a = s ? -x : x;
        e = 0;
        while (a >= 2.0) begin a = a / 2.0; e++; end
        while (a < 1.0)  begin a = a * 2.0; e--; end
        m = 23'($rtoi((a - 1.0) * 8388608.0));
        return {s, 8'(e + 127), m};
    endfunction

    function automatic logic [63:0] tree_add(input logic [NI*64-1:0] v);
        real re = 0.0;
        real im = 0.0;
        for (int i = 0; i < NI; i++) begin
            re += f2r(v[64*i+32 +: 32]);
            im += f2r(v[64*i +: 32]);
        end
        return {r2f(re), r2f(im)};
    endfunction

    // Reference: plain sum over every element of the job.
    function automatic logic [63:0] model_sum(input int k);
        real re = 0.0;
        real im = 0.0;
        for (int c = 0; c < k; c++)
            for (int i = 0; i < NI; i++) begin
                re += f2r(jd[c][64*i+32 +: 32]);
                im += f2r(jd[c][64*i +: 32]);
            end
        return {r2f(re), r2f(im)};
    endfunction

    function automatic int exp_cycle(input int k, input int gaps);
`ifdef CPLX_TREE_CTRL_SKIP_REDUCE_EN
        if (k == 1) return TL + 3 + gaps;
`endif
        return k + 2*TL + 4 + gaps;
    endfunction

    // Adder tree model: TL register stages after tree_inputs.
    always @(posedge clk) begin
        tree_pipe[0] <= tree_add(bus.tree_inputs);
        for (int i = 1; i < TL; i++) tree_pipe[i] <= tree_pipe[i-1];
    end
    assign bus.tree_sum = tree_pipe[TL-1];

    task automatic fill_const(input logic [63:0] v);
        for (int c = 0; c < 8; c++)
            for (int i = 0; i < NI; i++) jd[c][64*i +: 64] = v;
    endtask

    task automatic fill_random();
        for (int c = 0; c < 8; c++)
            for (int i = 0; i < NI; i++)
                jd[c][64*i +: 64] = {r2f(real'(int'($urandom_range(0, 32)) - 16) * 0.5),
                                     r2f(real'(int'($urandom_range(0, 32)) - 16) * 0.5)};
    endtask

    // Runs one job; cycle 0 is the cycle start is sampled. Stops linger cycles after result_valid.
    task automatic run_job(input int k, input int gap_pct, input int gap_after, input int gap_len,
                           input bit busy_start, input int linger, input int abort_drain,
                           output logic [63:0] res, output int vcyc, output int npulse, output int gaps);
        int cyc  = 0;
        int acc  = 0;
        int gcnt = 0;
        int d1   = 0;
        bit pend = 0;
        vcyc = -1; npulse = 0; gaps = 0; res = '0;
        @(posedge clk); #1;
        bus.start = 1'b1; bus.chunk_cnt = 3'(k - 1); bus.in_valid = 1'b0;
        while (cyc < 400) begin
            @(posedge clk); #1;
            cyc++;
            if (pend) acc++;
            pend = 0;
            bus.start = 1'b0;
            if (bus.result_valid) begin
                npulse++;
                if (vcyc < 0) begin vcyc = cyc; res = bus.result; end
            end
            if (abort_drain >= 0 && acc == k && bus.busy) begin
                if (d1 == abort_drain) begin
                    rst_n = 1'b0; bus.in_valid = 1'b0;
                    @(posedge clk); #1;
                    rst_n = 1'b1;
                    break;
                end
                d1++;
            end
            if (bus.in_ready && acc < k) begin
                if (acc == gap_after && gcnt < gap_len) begin
                    bus.in_valid = 1'b0; gcnt++; gaps++;
                end else if (int'($urandom_range(0, 99)) < gap_pct) begin
                    bus.in_valid = 1'b0; gaps++;
                end else begin
                    bus.in_valid = 1'b1; bus.in_data = jd[acc]; pend = 1;
                end
            end else begin
                bus.in_valid = 1'b0;
            end
            if (vcyc >= 0 && cyc >= vcyc + linger) break;
            if (busy_start && bus.busy && $urandom_range(0, 1) == 1) begin
                bus.start = 1'b1; bus.chunk_cnt = 3'($urandom);
            end
        end
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; bus.start = 1'b0; bus.chunk_cnt = '0; bus.in_valid = 1'b0; bus.in_data = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b exp=0", bus.in_ready); end
        total++; if (bus.result_valid !== 1'b0) begin bad++; $display("FAIL reset_result_valid got=%b exp=0", bus.result_valid); end
        total++; if (bus.result !== 64'h0) begin bad++; $display("FAIL reset_result got=%h exp=0", bus.result); end
        total++; if (bus.tree_inputs !== '0) begin bad++; $display("FAIL reset_tree_inputs got=%h exp=0", bus.tree_inputs); end
    endtask

    task automatic test_k8_const();
        logic [63:0] r; int vc, np, g;
        fill_const(64'h3F800000_40000000);
        run_job(8, 0, -1, 0, 0, 3, -1, r, vc, np, g);
        total++; if (r !== 64'h42800000_43000000) begin bad++; $display("FAIL k8_result got=%h exp=42800000_43000000", r); end
        total++; if (vc != 18) begin bad++; $display("FAIL k8_cycle got=%0d exp=18", vc); end
        total++; if (np != 1) begin bad++; $display("FAIL k8_pulses got=%0d exp=1", np); end
        total++; if (bus.busy !== 1'b0 || bus.tree_inputs !== '0) begin bad++; $display("FAIL k8_idle busy=%b tree=%h exp=0", bus.busy, bus.tree_inputs); end
    endtask

    task automatic test_k3_gap();
        logic [63:0] r; int vc, np, g;
        for (int c = 0; c < 8; c++)
            for (int i = 0; i < NI; i++) jd[c][64*i +: 64] = {r2f(real'(c + 1)), 32'h0};
        run_job(3, 0, 2, 2, 0, 3, -1, r, vc, np, g);
        total++; if (r !== 64'h42400000_00000000) begin bad++; $display("FAIL k3gap_result got=%h exp=42400000_00000000", r); end
        total++; if (vc != exp_cycle(3, 2)) begin bad++; $display("FAIL k3gap_cycle got=%0d exp=%0d", vc, exp_cycle(3, 2)); end
        total++; if (np != 1) begin bad++; $display("FAIL k3gap_pulses got=%0d exp=1", np); end
    endtask

    task automatic test_k1();
        logic [63:0] r; int vc, np, g; int ec;
`ifdef CPLX_TREE_CTRL_SKIP_REDUCE_EN
        ec = 6;
`else
        ec = 11;
`endif
        fill_const(64'h3F000000_BF000000);
        run_job(1, 0, -1, 0, 0, 3, -1, r, vc, np, g);
        total++; if (r !== 64'h40800000_C0800000) begin bad++; $display("FAIL k1_result got=%h exp=40800000_C0800000", r); end
        total++; if (vc != ec) begin bad++; $display("FAIL k1_cycle got=%0d exp=%0d", vc, ec); end
        total++; if (np != 1) begin bad++; $display("FAIL k1_pulses got=%0d exp=1", np); end
    endtask

    task automatic test_random();
        logic [63:0] r, e; int vc, np, g, k;
        for (int it = 0; it < 12; it++) begin
            k = int'($urandom_range(1, 8));
            fill_random();
            e = model_sum(k);
            run_job(k, 25, -1, 0, 0, 2, -1, r, vc, np, g);
            total++; if (r !== e) begin bad++; $display("FAIL rand_result it=%0d k=%0d got=%h exp=%h", it, k, r, e); end
            total++; if (vc != exp_cycle(k, g)) begin bad++; $display("FAIL rand_cycle it=%0d k=%0d got=%0d exp=%0d", it, k, vc, exp_cycle(k, g)); end
            total++; if (np != 1) begin bad++; $display("FAIL rand_pulses it=%0d got=%0d exp=1", it, np); end
        end
    endtask

    task automatic test_start_while_busy();
        logic [63:0] r, e; int vc, np, g;
        fill_random();
        e = model_sum(5);
        run_job(5, 20, -1, 0, 1, 8, -1, r, vc, np, g);
        total++; if (r !== e) begin bad++; $display("FAIL busystart_result got=%h exp=%h", r, e); end
        total++; if (vc != exp_cycle(5, g)) begin bad++; $display("FAIL busystart_cycle got=%0d exp=%0d", vc, exp_cycle(5, g)); end
        total++; if (np != 1) begin bad++; $display("FAIL busystart_pulses got=%0d exp=1", np); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL busystart_idle got=%b exp=0", bus.busy); end
    endtask

    task automatic test_back_to_back();
        logic [63:0] r, e; int vc, np, g, k;
        for (int j = 0; j < 2; j++) begin
            k = (j == 0) ? 1 : 7;
            fill_random();
            e = model_sum(k);
            run_job(k, 0, -1, 0, 0, 0, -1, r, vc, np, g);
            total++; if (r !== e) begin bad++; $display("FAIL b2b_result j=%0d got=%h exp=%h", j, r, e); end
            total++; if (vc != exp_cycle(k, 0)) begin bad++; $display("FAIL b2b_cycle j=%0d got=%0d exp=%0d", j, vc, exp_cycle(k, 0)); end
        end
    endtask

    task automatic test_reset_mid_job();
        logic [63:0] r, e; int vc, np, g;
        fill_random();
        run_job(8, 0, -1, 0, 0, 0, 0, r, vc, np, g);
        total++; if (np != 0) begin bad++; $display("FAIL midrst_aborted_pulses got=%0d exp=0", np); end
        total++; if (bus.busy !== 1'b0 || bus.result !== 64'h0) begin bad++; $display("FAIL midrst_cleared busy=%b result=%h exp=0", bus.busy, bus.result); end
        fill_random();
        e = model_sum(2);
        run_job(2, 0, -1, 0, 0, 3, -1, r, vc, np, g);
        total++; if (r !== e) begin bad++; $display("FAIL midrst_result got=%h exp=%h", r, e); end
        total++; if (vc != exp_cycle(2, 0)) begin bad++; $display("FAIL midrst_cycle got=%0d exp=%0d", vc, exp_cycle(2, 0)); end
        total++; if (np != 1) begin bad++; $display("FAIL midrst_pulses got=%0d exp=1", np); end
    endtask

    initial begin
        test_reset();
        test_k8_const();
        test_k3_gap();
        test_k1();
        test_random();
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid_job();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
